// File: rtl/rat_flags.sv
// Carry / zero / interrupt-enable flag register with interrupt-request edge capture.
// Define INTR_SYNC_EN to pass INTR through a 2-flop synchronizer before edge detection.
module rat_flags (
   input  logic clk,
   input  logic RST,
   input  logic C_IN,
   input  logic Z_IN,
   input  logic FLG_C_LD,
   input  logic FLG_C_SET,
   input  logic FLG_C_CLR,
   input  logic FLG_Z_LD,
   input  logic FLG_LD_SEL,
   input  logic SHAD_C_FLG,
   input  logic SHAD_Z_FLG,
   input  logic I_SET,
   input  logic I_CLR,
   input  logic INTR,
   input  logic INT_ACK,
   output logic C_FLG,
   output logic Z_FLG,
   output logic I_FLG,
   output logic INT_PEND
);

`ifdef INTR_SYNC_EN
   localparam int unsigned HIST_DEPTH = 3;
`else
   localparam int unsigned HIST_DEPTH = 1;
`endif

   logic c_flg_q, c_flg_d;
   logic z_flg_q, z_flg_d;
   logic i_flg_q, i_flg_d;
   logic pend_q, pend_d;
   logic int_pend_q, int_pend_d;
   logic intr_prev_q, intr_prev_d;
   logic [HIST_DEPTH-1:0] hist_vld_q, hist_vld_d;
   logic intr_smp;
   logic intr_edge;

`ifdef INTR_SYNC_EN
   logic intr_meta_q, intr_meta_d;
   logic intr_sync_q, intr_sync_d;

   always_comb begin
      intr_meta_d = INTR;
      intr_sync_d = intr_meta_q;
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         intr_meta_q <= 1'b0;
         intr_sync_q <= 1'b0;
      end else begin
         intr_meta_q <= intr_meta_d;
         intr_sync_q <= intr_sync_d;
      end
   end

   assign intr_smp = intr_sync_q;
`else
   assign intr_smp = INTR;
`endif

   // hist_vld marks which stages of the INTR history hold samples taken since reset,
   // so a level already high at reset release never looks like a rising edge.
   always_comb begin
      intr_prev_d = intr_smp;
      hist_vld_d  = (hist_vld_q << 1) | HIST_DEPTH'(1);
      intr_edge   = intr_smp & ~intr_prev_q & hist_vld_q[HIST_DEPTH-1];
   end

   // NOTE: every variable gets a default first, so no path through this block infers a latch.
   always_comb begin
      c_flg_d = c_flg_q;
      if (FLG_C_CLR)
         c_flg_d = 1'b0;
      else if (FLG_C_SET)
         c_flg_d = 1'b1;
      else if (FLG_C_LD)
         c_flg_d = FLG_LD_SEL ? SHAD_C_FLG : C_IN;

      z_flg_d = z_flg_q;
      if (FLG_Z_LD)
         z_flg_d = FLG_LD_SEL ? SHAD_Z_FLG : Z_IN;

      i_flg_d = i_flg_q;
      if (INT_ACK || I_CLR)
         i_flg_d = 1'b0;
      else if (I_SET)
         i_flg_d = 1'b1;

      // Edges seen while interrupts are disabled, or alongside an ack, are dropped.
      pend_d = pend_q;
      if (INT_ACK)
         pend_d = 1'b0;
      else if (intr_edge && i_flg_q)
         pend_d = 1'b1;

      int_pend_d = pend_d & i_flg_d;
   end

   // NOTE: sequential state uses non-blocking assignments only; every flop is reset.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         c_flg_q     <= 1'b0;
         z_flg_q     <= 1'b0;
         i_flg_q     <= 1'b0;
         pend_q      <= 1'b0;
         int_pend_q  <= 1'b0;
         intr_prev_q <= 1'b0;
         hist_vld_q  <= '0;
      end else begin
         c_flg_q     <= c_flg_d;
         z_flg_q     <= z_flg_d;
         i_flg_q     <= i_flg_d;
         pend_q      <= pend_d;
         int_pend_q  <= int_pend_d;
         intr_prev_q <= intr_prev_d;
         hist_vld_q  <= hist_vld_d;
      end
   end

   assign C_FLG    = c_flg_q;
   assign Z_FLG    = z_flg_q;
   assign I_FLG    = i_flg_q;
   assign INT_PEND = int_pend_q;

endmodule

// File: tb/tb_rat_flags.sv
// Self-checking bench for rat_flags: directed scenarios plus random traffic against a sample-history model.
module tb_rat_flags;

`ifdef INTR_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic RST;
   logic C_IN, Z_IN, FLG_C_LD, FLG_C_SET, FLG_C_CLR, FLG_Z_LD, FLG_LD_SEL;
   logic SHAD_C_FLG, SHAD_Z_FLG, I_SET, I_CLR, INTR, INT_ACK;
   logic C_FLG, Z_FLG, I_FLG, INT_PEND;

   int n_cmp = 0;
   int n_err = 0;

   rat_flags dut (
      .clk        (clk),
      .RST        (RST),
      .C_IN       (C_IN),
      .Z_IN       (Z_IN),
      .FLG_C_LD   (FLG_C_LD),
      .FLG_C_SET  (FLG_C_SET),
      .FLG_C_CLR  (FLG_C_CLR),
      .FLG_Z_LD   (FLG_Z_LD),
      .FLG_LD_SEL (FLG_LD_SEL),
      .SHAD_C_FLG (SHAD_C_FLG),
      .SHAD_Z_FLG (SHAD_Z_FLG),
      .I_SET      (I_SET),
      .I_CLR      (I_CLR),
      .INTR       (INTR),
      .INT_ACK    (INT_ACK),
      .C_FLG      (C_FLG),
      .Z_FLG      (Z_FLG),
      .I_FLG      (I_FLG),
      .INT_PEND   (INT_PEND)
   );

   always #5 clk = ~clk;

   // Reference model: flag values plus every INTR value sampled since the last reset.
   bit m_c, m_z, m_i, m_pend, m_int_pend;
   bit samp[$];

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_c = 0; m_z = 0; m_i = 0; m_pend = 0; m_int_pend = 0;
      samp.delete();
   endfunction

   function automatic void model_edge();
      int  k;
      bit  rise;
      bit  i_new;
      bit  p_new;
      if (RST) begin
         model_reset();
         return;
      end
      samp.push_back(INTR);
      k = samp.size();
      // A rise is seen LAT-1 samples late; the sample before it must also postdate reset.
      rise = 0;
      if (k - LAT >= 1)
         rise = samp[k-LAT] && !samp[k-LAT-1];

      if (FLG_C_CLR)      m_c = 0;
      else if (FLG_C_SET) m_c = 1;
      else if (FLG_C_LD)  m_c = FLG_LD_SEL ? SHAD_C_FLG : C_IN;
      if (FLG_Z_LD)       m_z = FLG_LD_SEL ? SHAD_Z_FLG : Z_IN;

      if (INT_ACK)          i_new = 0;
      else if (I_CLR)       i_new = 0;
      else if (I_SET)       i_new = 1;
      else                  i_new = m_i;

      if (INT_ACK)          p_new = 0;
      else if (rise && m_i) p_new = 1;
      else                  p_new = m_pend;

      m_i        = i_new;
      m_pend     = p_new;
      m_int_pend = p_new & i_new;
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("C_FLG", C_FLG, m_c);
      check("Z_FLG", Z_FLG, m_z);
      check("I_FLG", I_FLG, m_i);
      check("INT_PEND", INT_PEND, m_int_pend);
   endtask

   initial begin
      RST = 1; C_IN = 0; Z_IN = 0; FLG_C_LD = 0; FLG_C_SET = 0; FLG_C_CLR = 0;
      FLG_Z_LD = 0; FLG_LD_SEL = 0; SHAD_C_FLG = 0; SHAD_Z_FLG = 0;
      I_SET = 0; I_CLR = 0; INTR = 0; INT_ACK = 0;
      model_reset();

      // Reset state and C load
      C_IN = 1;
      repeat (2) step();
      check("rst_c", C_FLG, 1'b0);
      check("rst_z", Z_FLG, 1'b0);
      check("rst_i", I_FLG, 1'b0);
      check("rst_pend", INT_PEND, 1'b0);
      RST = 0;
      FLG_C_LD = 1; step(); check("c_load", C_FLG, 1'b1);
      FLG_C_LD = 0; C_IN = 0; step(); check("c_hold", C_FLG, 1'b1);

      // C priority
      C_IN = 1; FLG_C_CLR = 1; FLG_C_SET = 1; FLG_C_LD = 1;
      step(); check("c_prio_clr", C_FLG, 1'b0);
      FLG_C_CLR = 0; C_IN = 0;
      step(); check("c_prio_set", C_FLG, 1'b1);
      FLG_C_SET = 0; FLG_C_LD = 0;

      // Shadow restore
      FLG_C_CLR = 1; FLG_Z_LD = 1; Z_IN = 0; FLG_LD_SEL = 0;
      step(); check("pre_rest_c", C_FLG, 1'b0); check("pre_rest_z", Z_FLG, 1'b0);
      FLG_C_CLR = 0; SHAD_C_FLG = 1; SHAD_Z_FLG = 1; FLG_LD_SEL = 1; FLG_C_LD = 1;
      step(); check("restore_c", C_FLG, 1'b1); check("restore_z", Z_FLG, 1'b1);
      FLG_C_LD = 0; FLG_Z_LD = 0; FLG_LD_SEL = 0;

      // Interrupt latency, ack, and single event per held level
      I_SET = 1; step(); check("sei", I_FLG, 1'b1); I_SET = 0;
      INTR = 1;
      for (int e = 1; e <= 10; e++) begin
         step();
         check("int_latency", INT_PEND, e >= LAT);
      end
      INT_ACK = 1; step(); INT_ACK = 0;
      check("ack_pend", INT_PEND, 1'b0);
      check("ack_i", I_FLG, 1'b0);
      I_SET = 1; step(); I_SET = 0;
      repeat (5) begin
         step();
         check("held_no_reedge", INT_PEND, 1'b0);
      end

      // Masking: edge while disabled is discarded
      INTR = 0; I_CLR = 1; step(); I_CLR = 0;
      check("cli", I_FLG, 1'b0);
      repeat (LAT + 1) step();
      INTR = 1; step(); INTR = 0;
      repeat (LAT + 2) step();
      I_SET = 1; step(); I_SET = 0;
      repeat (LAT + 2) begin
         step();
         check("masked_dropped", INT_PEND, 1'b0);
      end
      INTR = 1;
      repeat (LAT) step();
      check("unmasked_edge", INT_PEND, 1'b1);
      I_CLR = 1; step(); I_CLR = 0;
      check("pend_hidden", INT_PEND, 1'b0);
      check("cli2", I_FLG, 1'b0);
      step(); check("pend_hidden2", INT_PEND, 1'b0);
      I_SET = 1; step(); I_SET = 0;
      check("pend_returns", INT_PEND, 1'b1);

      // Async reset mid-operation, INTR held high through release
      #3; RST = 1; #1;
      check("arst_pend", INT_PEND, 1'b0);
      check("arst_i", I_FLG, 1'b0);
      check("arst_c", C_FLG, 1'b0);
      check("arst_z", Z_FLG, 1'b0);
      step();
      RST = 0;
      I_SET = 1; step(); I_SET = 0;
      repeat (10) begin
         step();
         check("no_edge_after_rst", INT_PEND, 1'b0);
      end

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         RST        = ($urandom_range(199) == 0);
         C_IN       = 1'($urandom_range(1));
         Z_IN       = 1'($urandom_range(1));
         SHAD_C_FLG = 1'($urandom_range(1));
         SHAD_Z_FLG = 1'($urandom_range(1));
         FLG_LD_SEL = 1'($urandom_range(1));
         FLG_C_LD   = ($urandom_range(99) < 30);
         FLG_C_SET  = ($urandom_range(99) < 10);
         FLG_C_CLR  = ($urandom_range(99) < 10);
         FLG_Z_LD   = ($urandom_range(99) < 30);
         I_SET      = ($urandom_range(99) < 20);
         I_CLR      = ($urandom_range(99) < 8);
         INT_ACK    = ($urandom_range(99) < 6);
         if ($urandom_range(99) < 15) INTR = ~INTR;
         step();
      end
      RST = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
